// File: rtl/asip_pkg.sv
// rtl/asip_pkg.sv - shared widths, encodings and fetch state for the ASIP pipeline
package asip_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;

  localparam logic [ADDR_W-1:0]  RESET_PC   = 8'h00;
  localparam logic [ADDR_W-1:0]  PC_STEP    = 8'h04;
  localparam logic [INSTR_W-1:0] NOP_INSTR  = 16'h0000;
  localparam logic [INSTR_W-1:0] HALT_INSTR = 16'hFFFF;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage control, memory and IF/ID bus
interface fetch_stage_if;
  import asip_pkg::*;

  logic               stall;
  logic               branch_taken;
  logic [ADDR_W-1:0]  branch_target;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] if_id_instr;
  logic [ADDR_W-1:0]  if_id_pc;
  logic               if_id_valid;
  logic               halted;
  logic [15:0]        fetch_count;

  // Fetch stage side: drives the memory address and the IF/ID outputs
  modport master (
    input  stall, branch_taken, branch_target, imem_rdata,
    output imem_addr, if_id_instr, if_id_pc, if_id_valid, halted, fetch_count
  );

  // Surrounding pipeline / memory side
  modport slave (
    output stall, branch_taken, branch_target, imem_rdata,
    input  imem_addr, if_id_instr, if_id_pc, if_id_valid, halted, fetch_count
  );

endinterface

// File: rtl/fetch_stage_pc_register.sv
// rtl/fetch_stage_pc_register.sv - program counter with redirect, advance and wrap
module pc_register
  import asip_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              advance_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Next PC: redirect is word-aligned, advance wraps naturally at 2^ADDR_W
  always_comb begin
    pc_d = pc_q;
    if (branch_taken_i) begin
      pc_d = branch_target_i & ~ADDR_W'(3);
    end else if (advance_i) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  // PC storage
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, IF/ID register, halt and fetch counter
module fetch_stage
  import asip_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  fetch_state_e       state_q;
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  ifpc_q;
  logic               valid_q;
  logic [15:0]        count_q;
  logic [ADDR_W-1:0]  pc;
  logic               advance;
  logic               is_halt;

  assign is_halt = (bus.imem_rdata == HALT_INSTR);

  // PC moves forward only on a normal capture of a non-HALT word
  assign advance = !bus.stall && (state_q == RUN) && !is_halt;

  pc_register u_pc (
    .clk             (clk),
    .rst             (rst),
    .branch_taken_i  (bus.branch_taken),
    .branch_target_i (bus.branch_target),
    .advance_i       (advance),
    .pc_o            (pc)
  );

  // Run/halt state, IF/ID register and saturating fetch counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      instr_q <= NOP_INSTR;
      ifpc_q  <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else if (bus.branch_taken) begin
      state_q <= RUN;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (bus.stall) begin
      state_q <= state_q;
    end else if (state_q == HALTED) begin
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else begin
      instr_q <= bus.imem_rdata;
      ifpc_q  <= pc;
      valid_q <= 1'b1;
      if (count_q != 16'hFFFF) begin
        count_q <= count_q + 16'd1;
      end
      if (is_halt) begin
        state_q <= HALTED;
      end
    end
  end

  assign bus.imem_addr   = pc;
  assign bus.if_id_instr = instr_q;
  assign bus.if_id_pc    = ifpc_q;
  assign bus.if_id_valid = valid_q;
  assign bus.halted      = (state_q == HALTED);
  assign bus.fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic [15:0] rom [64];

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.imem_rdata = rom[bus.imem_addr[7:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_if(input string tag, input logic [15:0] instr,
                          input logic [7:0] pc, input logic valid);
    check({tag, "_instr"}, 32'(bus.if_id_instr), 32'(instr));
    check({tag, "_pc"},    32'(bus.if_id_pc),    32'(pc));
    check({tag, "_valid"}, 32'(bus.if_id_valid), 32'(valid));
  endtask

  task automatic check_reset(input string tag);
    check_if(tag, 16'h0000, 8'h00, 1'b0);
    check({tag, "_addr"},   32'(bus.imem_addr),   32'h00);
    check({tag, "_halted"}, 32'(bus.halted),      32'h0);
    check({tag, "_count"},  32'(bus.fetch_count), 32'h0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 64; i++) rom[i] = 16'h1001 + 16'(i);
    rom[4] = 16'hFFFF;

    rst = 1'b1;
    bus.stall = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_target = 8'h00;
    tick();
    check_reset("reset");
    rst = 1'b0;

    // Free run of four words
    tick(); check_if("run0", 16'h1001, 8'h00, 1'b1);
    tick(); check_if("run1", 16'h1002, 8'h04, 1'b1);
    tick(); check_if("run2", 16'h1003, 8'h08, 1'b1);
    tick(); check_if("run3", 16'h1004, 8'h0C, 1'b1);
    check("run_count", 32'(bus.fetch_count), 32'd4);

    // Restart and stall at pc 0x08
    rst = 1'b1; tick(); rst = 1'b0;
    tick(); tick();
    check("pre_stall_addr", 32'(bus.imem_addr), 32'h08);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_addr", 32'(bus.imem_addr), 32'h08);
      check_if("stall", 16'h1002, 8'h04, 1'b1);
      check("stall_count", 32'(bus.fetch_count), 32'd2);
    end
    bus.stall = 1'b0;
    tick(); check_if("resume", 16'h1003, 8'h08, 1'b1);
    check("resume_count", 32'(bus.fetch_count), 32'd3);

    // Branch wins over stall
    bus.stall = 1'b1;
    bus.branch_taken = 1'b1;
    bus.branch_target = 8'h23;
    tick();
    bus.stall = 1'b0;
    bus.branch_taken = 1'b0;
    check("br_addr", 32'(bus.imem_addr), 32'h20);
    check("br_valid", 32'(bus.if_id_valid), 32'h0);
    check("br_instr", 32'(bus.if_id_instr), 32'h0000);
    check("br_count", 32'(bus.fetch_count), 32'd3);
    tick(); check_if("br_tgt", 16'h1009, 8'h20, 1'b1);

    // Run into HALT at 0x10
    bus.branch_taken = 1'b1;
    bus.branch_target = 8'h0C;
    tick();
    bus.branch_taken = 1'b0;
    tick(); check_if("pre_halt", 16'h1004, 8'h0C, 1'b1);
    tick(); check_if("halt", 16'hFFFF, 8'h10, 1'b1);
    check("halt_flag", 32'(bus.halted), 32'h1);
    check("halt_addr", 32'(bus.imem_addr), 32'h10);
    check("halt_count", 32'(bus.fetch_count), 32'd6);
    tick(); check_if("halt_bub", 16'h0000, 8'h10, 1'b0);
    tick(); check_if("halt_bub2", 16'h0000, 8'h10, 1'b0);
    check("halt_addr2", 32'(bus.imem_addr), 32'h10);
    check("halt_count2", 32'(bus.fetch_count), 32'd6);

    // Branch out of HALTED
    bus.branch_taken = 1'b1;
    bus.branch_target = 8'h00;
    tick();
    bus.branch_taken = 1'b0;
    check("unhalt_flag", 32'(bus.halted), 32'h0);
    check("unhalt_valid", 32'(bus.if_id_valid), 32'h0);
    tick(); check_if("refetch", 16'h1001, 8'h00, 1'b1);
    check("refetch_count", 32'(bus.fetch_count), 32'd7);

    // PC wrap at 0xFC
    bus.branch_taken = 1'b1;
    bus.branch_target = 8'hFC;
    tick();
    bus.branch_taken = 1'b0;
    check("wrap_addr0", 32'(bus.imem_addr), 32'hFC);
    tick(); check_if("wrap0", 16'h1040, 8'hFC, 1'b1);
    check("wrap_addr1", 32'(bus.imem_addr), 32'h00);
    tick(); check_if("wrap1", 16'h1001, 8'h00, 1'b1);

    // Reset while halted and stalled
    bus.branch_taken = 1'b1;
    bus.branch_target = 8'h10;
    tick();
    bus.branch_taken = 1'b0;
    tick();
    check("pre_rst_halted", 32'(bus.halted), 32'h1);
    bus.stall = 1'b1;
    rst = 1'b1;
    tick();
    check_reset("mid_rst");
    rst = 1'b0;
    bus.stall = 1'b0;
    tick(); check_if("post_rst", 16'h1001, 8'h00, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the vectorial ASIP pipeline, directly upstream of the instruction memory and feeding the decode stage. It owns the program counter, presents a byte address to the combinational-read instruction memory (8-bit byte address, 16-bit word, word index = address[7:2]), and captures the returned instruction into the IF/ID pipeline register. It also handles decode-stage stalls, branch redirects from the execute stage, HALT detection and a saturating fetch counter.

## Interface
- ADDR_W, 8, PC / byte-address width
- INSTR_W, 16, instruction width
- RESET_PC, 8'h00, PC value after reset
- NOP_INSTR, 16'h0000, bubble encoding loaded into IF/ID
- HALT_INSTR, 16'hFFFF, encoding that stops fetch
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  decode cannot accept; hold PC and IF/ID
- branch_taken  in  1  redirect request from execute
- branch_target  in  ADDR_W  redirect byte address
- imem_addr  out  ADDR_W  address to instruction memory (= PC)
- imem_rdata  in  INSTR_W  instruction from memory, valid same cycle
- if_id_instr  out  INSTR_W  registered instruction to decode
- if_id_pc  out  ADDR_W  byte address of if_id_instr
- if_id_valid  out  1  if_id_instr is a real instruction
- halted  out  1  HALT has been fetched; fetch frozen
- fetch_count  out  16  instructions accepted into IF/ID, saturating

## Operation
- imem_addr = pc combinationally; pc[1:0] always 2'b00.
- Per-edge priority (highest first):
  - rst: pc=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_valid=0, halted=0, fetch_count=0.
  - branch_taken: pc={branch_target[7:2],2'b00}; IF/ID = bubble (NOP_INSTR, valid=0, if_id_pc unchanged); halted cleared. Overrides stall and halted.
  - stall: pc, IF/ID, halted, fetch_count all hold.
  - halted: pc holds; IF/ID = bubble.
  - normal: if_id_instr=imem_rdata, if_id_pc=pc, if_id_valid=1, pc=pc+4, fetch_count+1 (saturates at 16'hFFFF); if imem_rdata==HALT_INSTR also set halted=1 and pc holds instead of incrementing.
- PC arithmetic modulo 2^ADDR_W: pc 8'hFC advances to 8'h00.
- HALT itself is delivered to decode with valid=1 and counted; nothing after it is.
- Two states: RUN, HALTED. RUN->HALTED on normal capture of HALT_INSTR; HALTED->RUN on branch_taken; any->RUN on rst.

## Timing
- Memory read is combinational: instruction at pc appears on if_id_instr one edge after pc is presented.
- Fetch-to-decode latency 1 cycle; throughput 1 instr/cycle without stall.
- Branch penalty: 1 bubble; target instruction in IF/ID on the second edge after branch_taken is sampled.
- stall is level-sensitive; held N cycles freezes outputs N cycles, no instruction lost or duplicated.
- stall and branch_taken same cycle: branch wins.
- HALT fetched while stall high: not captured until stall drops.
- rst mid-operation: all outputs at reset values after that edge, regardless of stall/branch.

## Structure
- Shared package asip_pkg: ADDR_W, INSTR_W, NOP_INSTR, HALT_INSTR, PC_STEP (=4), fetch state enum {RUN, HALTED}.
- One sub-module: pc_register (PC storage, next-PC mux, alignment, wrap). IF/ID register, state and counter stay in fetch_stage.

## Test plan
- Reset then 4 free-running cycles, memory words 0..3 = 16'h1001..16'h1004 -> if_id_instr 1001,1002,1003,1004 with if_id_pc 00,04,08,0C; valid=1; fetch_count=4.
- stall high 3 cycles at pc=8'h08 -> imem_addr stays 8'h08, IF/ID holds 16'h1002/8'h04, fetch_count unchanged; resumes with 16'h1003.
- branch_taken with branch_target=8'h23 (stall also high) -> next edge pc=8'h20, if_id_valid=0; following edge if_id_instr=ROM[8], if_id_pc=8'h20.
- HALT (16'hFFFF) at 8'h10 -> delivered with valid=1, halted=1, pc frozen at 8'h10, subsequent IF/ID bubbles; later branch to 8'h00 clears halted and refetches 16'h1001.
- pc at 8'hFC, free run -> next pc 8'h00, if_id_pc 8'hFC then 8'h00.
- rst asserted during stall with halted=1 -> after edge all outputs at reset values, pc=8'h00.
